// File: rtl/cpe_data_mem.sv
// cpe_data_mem: byte-addressed big-endian data RAM answering the cpe_cpu load/store port,
// with alignment/range checking, 1-cycle registered loads and a post-reset clear sweep.
module cpe_data_mem #(
   parameter int ADDR_BITS      = 16,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic        clk_w_i,
   input  logic        res_w_i_l,
   input  logic [31:0] mem_addr_w_i,
   input  logic [31:0] mem_data_w_i,
   input  logic        mem_wr_w_i_h,
   input  logic        mem_rd_w_i_h,
   input  logic [1:0]  mem_wr_byte_sel_w_i,
   input  logic [1:0]  mem_rd_byte_sel_w_i,
   output logic [31:0] mem_data_w_o,
   output logic        mem_rd_vld_w_o_h,
   output logic        mem_rdy_w_o_h,
   output logic        mem_err_w_o_h
);
   typedef enum logic {S_INIT, S_IDLE} state_t;
   state_t                 r_state;
   logic [ADDR_BITS-3:0]   r_cnt;
   logic [7:0]             r_mem [0:(1<<ADDR_BITS)-1];
   logic [31:0]            r_data;
   logic                   r_vld, r_err, r_rdy;
   logic [1:0]             w_size;
   logic                   w_req, w_bad, w_err, w_we, w_re;
   logic [ADDR_BITS-1:0]   w_i0, w_h1, w_w0, w_w1, w_w2, w_w3;
   logic [31:0]            w_rdata;
   // A load request decides the size when both are asserted; that case errors anyway.
   assign w_size = mem_rd_w_i_h ? mem_rd_byte_sel_w_i : mem_wr_byte_sel_w_i;
   assign w_req  = (mem_rd_w_i_h || mem_wr_w_i_h) && r_state == S_IDLE;
   assign w_bad  = (mem_rd_w_i_h && mem_wr_w_i_h) || w_size == 2'b11
                || (w_size == 2'b01 && mem_addr_w_i[0])
                || (w_size == 2'b10 && mem_addr_w_i[1:0] != 2'b00)
                || |(mem_addr_w_i >> ADDR_BITS);
   assign w_err  = w_req && w_bad;
   assign w_we   = w_req && mem_wr_w_i_h && !w_bad;
   assign w_re   = w_req && mem_rd_w_i_h;
   // Aligned accesses only, so byte offsets are ORed in rather than added.
   assign w_i0   = mem_addr_w_i[ADDR_BITS-1:0];
   assign w_h1   = {w_i0[ADDR_BITS-1:1], 1'b1};
   assign w_w0   = {w_i0[ADDR_BITS-1:2], 2'd0};
   assign w_w1   = {w_i0[ADDR_BITS-1:2], 2'd1};
   assign w_w2   = {w_i0[ADDR_BITS-1:2], 2'd2};
   assign w_w3   = {w_i0[ADDR_BITS-1:2], 2'd3};
   assign w_rdata = w_size == 2'b00 ? {24'b0, r_mem[w_i0]}
                  : w_size == 2'b01 ? {16'b0, r_mem[w_i0], r_mem[w_h1]}
                  : {r_mem[w_w0], r_mem[w_w1], r_mem[w_w2], r_mem[w_w3]};
   always_ff @(posedge clk_w_i) begin
      if (res_w_i_l && r_state == S_INIT) begin
         r_mem[{r_cnt, 2'd0}] <= 8'h00;
         r_mem[{r_cnt, 2'd1}] <= 8'h00;
         r_mem[{r_cnt, 2'd2}] <= 8'h00;
         r_mem[{r_cnt, 2'd3}] <= 8'h00;
      end else if (w_we) begin
         if (w_size == 2'b00) begin
            r_mem[w_i0] <= mem_data_w_i[7:0];
         end else if (w_size == 2'b01) begin
            r_mem[w_i0] <= mem_data_w_i[15:8];
            r_mem[w_h1] <= mem_data_w_i[7:0];
         end else begin
            r_mem[w_w0] <= mem_data_w_i[31:24];
            r_mem[w_w1] <= mem_data_w_i[23:16];
            r_mem[w_w2] <= mem_data_w_i[15:8];
            r_mem[w_w3] <= mem_data_w_i[7:0];
         end
      end
   end
   always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
      if (!res_w_i_l) begin
         r_state <= CLEAR_ON_RESET ? S_INIT : S_IDLE;
         r_cnt   <= '0;
         r_data  <= '0;
         r_vld   <= 1'b0;
         r_err   <= 1'b0;
         r_rdy   <= 1'b0;
      end else begin
         r_err <= w_err;
         r_vld <= w_re;
         if (w_re)
            r_data <= w_bad ? 32'h0 : w_rdata;
         if (r_state == S_INIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (&r_cnt) begin
               r_state <= S_IDLE;
               r_rdy   <= 1'b1;
            end
         end else begin
            r_rdy <= 1'b1;
         end
      end
   end
   assign mem_data_w_o     = r_data;
   assign mem_rd_vld_w_o_h = r_vld;
   assign mem_rdy_w_o_h    = r_rdy;
   assign mem_err_w_o_h    = r_err;
endmodule

// File: tb/tb_cpe_data_mem.sv
// tb_cpe_data_mem: scoreboard bench for cpe_data_mem with ADDR_BITS=8 (64-word clear sweep).
module tb_cpe_data_mem;
   localparam int AB = 8;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic        wr = 1'b0, rd = 1'b0;
   logic [1:0]  wsel = '0, rsel = '0;
   logic [31:0] dout;
   logic        vld, rdy, err;
   int          n_chk = 0, n_fail = 0;

   typedef struct {
      logic rd, wr;
      logic [1:0] rs, ws;
      logic [31:0] a, d;
      logic [33:0] exp;
   } op_t;

   logic [33:0] sb[$];

   cpe_data_mem #(.ADDR_BITS(AB), .CLEAR_ON_RESET(1'b1)) dut (
      .clk_w_i(clk), .res_w_i_l(rst_n),
      .mem_addr_w_i(addr), .mem_data_w_i(wdata),
      .mem_wr_w_i_h(wr), .mem_rd_w_i_h(rd),
      .mem_wr_byte_sel_w_i(wsel), .mem_rd_byte_sel_w_i(rsel),
      .mem_data_w_o(dout), .mem_rd_vld_w_o_h(vld),
      .mem_rdy_w_o_h(rdy), .mem_err_w_o_h(err)
   );

   always #5 clk = ~clk;

   function automatic op_t mk(logic r, logic w, logic [1:0] rs, logic [1:0] ws, logic [31:0] a,
                              logic [31:0] d, logic ev, logic ee, logic [31:0] ed);
      op_t o;
      o.rd = r; o.wr = w; o.rs = rs; o.ws = ws; o.a = a; o.d = d;
      o.exp = {ev, ee, ed};
      return o;
   endfunction

   // Drives one request at the current (falling) edge and queues its expected outcome.
   task automatic drive(op_t o);
      rd = o.rd; wr = o.wr; rsel = o.rs; wsel = o.ws; addr = o.a; wdata = o.d;
      sb.push_back(o.exp);
   endtask

   task automatic idle();
      rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; rsel = '0; wsel = '0;
   endtask

   task automatic test_reset();
      int n;
      logic stray;
      op_t ops[$];
      logic [33:0] e;
      repeat (2) @(negedge clk);
      n_chk++;
      if ({dout, vld, rdy, err} !== 35'h0) begin
         $display("FAIL reset_outputs: got data=%h vld=%b rdy=%b err=%b, want all 0", dout, vld, rdy, err);
         n_fail++;
      end
      wr = 1'b1; wsel = 2'b10; addr = 32'h40; wdata = 32'hCAFEF00D;
      rst_n = 1'b1;
      n = 0; stray = 1'b0;
      while (n < 200) begin
         @(posedge clk); #1;
         n++;
         if (rdy) break;
         if (vld || err) stray = 1'b1;
      end
      idle();
      n_chk++;
      if (n !== 64) begin
         $display("FAIL init_length: got %0d cycles with rdy=0, want 64", n);
         n_fail++;
      end
      n_chk++;
      if (stray !== 1'b0) begin
         $display("FAIL init_ignores_req: got vld/err activity during INIT, want none");
         n_fail++;
      end
      @(negedge clk);
      ops.push_back(mk(1, 0, 2'b10, 2'b00, 32'hFC, 0, 1, 0, 32'h0));
      ops.push_back(mk(1, 0, 2'b10, 2'b00, 32'h40, 0, 1, 0, 32'h0));
      foreach (ops[i]) begin
         drive(ops[i]);
         @(negedge clk);
         e = sb.pop_front();
         n_chk++;
         if ({vld, err, dout} !== e) begin
            $display("FAIL reset_load[%0d]: got vld=%b err=%b data=%h, want vld=%b err=%b data=%h",
                     i, vld, err, dout, e[33], e[32], e[31:0]);
            n_fail++;
         end
      end
      idle();
   endtask

   task automatic test_basic();
      op_t ops[$];
      logic [33:0] e;
      ops.push_back(mk(0, 1, 2'b00, 2'b10, 32'h10, 32'h11223344, 0, 0, 32'h0));
      ops.push_back(mk(1, 0, 2'b00, 2'b00, 32'h11, 0, 1, 0, 32'h00000022));
      ops.push_back(mk(1, 0, 2'b01, 2'b00, 32'h12, 0, 1, 0, 32'h00003344));
      ops.push_back(mk(0, 1, 2'b00, 2'b00, 32'h13, 32'h000000AB, 0, 0, 32'h00003344));
      ops.push_back(mk(1, 0, 2'b10, 2'b00, 32'h10, 0, 1, 0, 32'h112233AB));
      ops.push_back(mk(0, 0, 2'b00, 2'b00, 32'h0, 0, 0, 0, 32'h112233AB));
      ops.push_back(mk(0, 1, 2'b00, 2'b01, 32'h30, 32'h0000BEEF, 0, 0, 32'h112233AB));
      ops.push_back(mk(1, 0, 2'b01, 2'b00, 32'h30, 0, 1, 0, 32'h0000BEEF));
      ops.push_back(mk(1, 0, 2'b00, 2'b00, 32'h31, 0, 1, 0, 32'h000000EF));
      foreach (ops[i]) begin
         drive(ops[i]);
         @(negedge clk);
         e = sb.pop_front();
         n_chk++;
         if ({vld, err, dout} !== e) begin
            $display("FAIL basic[%0d]: got vld=%b err=%b data=%h, want vld=%b err=%b data=%h",
                     i, vld, err, dout, e[33], e[32], e[31:0]);
            n_fail++;
         end
      end
      idle();
   endtask

   task automatic test_errors();
      op_t ops[$];
      logic [33:0] e;
      ops.push_back(mk(1, 0, 2'b01, 2'b00, 32'h11, 0, 1, 1, 32'h0));
      ops.push_back(mk(1, 0, 2'b10, 2'b00, 32'h12, 0, 1, 1, 32'h0));
      ops.push_back(mk(1, 0, 2'b10, 2'b00, 32'h00010000, 0, 1, 1, 32'h0));
      ops.push_back(mk(1, 0, 2'b10, 2'b00, 32'h10, 0, 1, 0, 32'h112233AB));
      ops.push_back(mk(1, 0, 2'b10, 2'b00, 32'h110, 0, 1, 1, 32'h0));
      ops.push_back(mk(1, 0, 2'b11, 2'b00, 32'h10, 0, 1, 1, 32'h0));
      ops.push_back(mk(0, 1, 2'b00, 2'b10, 32'h12, 32'hDEADBEEF, 0, 1, 32'h0));
      ops.push_back(mk(0, 1, 2'b00, 2'b10, 32'h110, 32'hDEADBEEF, 0, 1, 32'h0));
      ops.push_back(mk(0, 1, 2'b00, 2'b11, 32'h10, 32'hDEADBEEF, 0, 1, 32'h0));
      ops.push_back(mk(1, 1, 2'b10, 2'b10, 32'h20, 32'hFFFFFFFF, 1, 1, 32'h0));
      ops.push_back(mk(1, 0, 2'b10, 2'b00, 32'h20, 0, 1, 0, 32'h0));
      ops.push_back(mk(1, 0, 2'b10, 2'b00, 32'h10, 0, 1, 0, 32'h112233AB));
      ops.push_back(mk(0, 0, 2'b00, 2'b00, 32'h0, 0, 0, 0, 32'h112233AB));
      foreach (ops[i]) begin
         drive(ops[i]);
         @(negedge clk);
         e = sb.pop_front();
         n_chk++;
         if ({vld, err, dout} !== e) begin
            $display("FAIL errors[%0d]: got vld=%b err=%b data=%h, want vld=%b err=%b data=%h",
                     i, vld, err, dout, e[33], e[32], e[31:0]);
            n_fail++;
         end
      end
      idle();
   endtask

   task automatic test_reset_midway();
      int n;
      logic seen;
      rd = 1'b1; rsel = 2'b10; addr = 32'h10;
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if ({dout, vld, rdy, err} !== 35'h0) begin
         $display("FAIL reset_async: got data=%h vld=%b rdy=%b err=%b, want all 0", dout, vld, rdy, err);
         n_fail++;
      end
      idle();
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (vld) seen = 1'b1;
      end
      n_chk++;
      if (seen !== 1'b0) begin
         $display("FAIL reset_drops_load: got vld pulse, want none");
         n_fail++;
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if (rdy !== 1'b0) begin
         $display("FAIL reset_mid_init: got rdy=%b, want 0", rdy);
         n_fail++;
      end
      @(negedge clk) rst_n = 1'b1;
      n = 0;
      while (n < 200) begin
         @(posedge clk); #1;
         n++;
         if (rdy) break;
      end
      n_chk++;
      if (n !== 64) begin
         $display("FAIL init_restart: got %0d cycles with rdy=0, want 64", n);
         n_fail++;
      end
      @(negedge clk);
      wr = 1'b1; wsel = 2'b10; addr = 32'h10; wdata = 32'h5A5A5A5A;
      @(negedge clk);
      wr = 1'b0; rd = 1'b1; rsel = 2'b10;
      @(posedge clk); #1;
      idle();
      n_chk++;
      if ({vld, dout} !== {1'b1, 32'h5A5A5A5A}) begin
         $display("FAIL load_before_reset: got vld=%b data=%h, want vld=1 data=5a5a5a5a", vld, dout);
         n_fail++;
      end
      #1 rst_n = 1'b0;
      #1;
      n_chk++;
      if ({dout, vld, err} !== 34'h0) begin
         $display("FAIL reset_mid_read: got data=%h vld=%b err=%b, want all 0", dout, vld, err);
         n_fail++;
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_errors();
      test_reset_midway();
      n_chk++;
      if (sb.size() !== 0) begin
         $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
         n_fail++;
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
